// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core.
// This package holds the SQI read-controller additions.
package idli_pkg;

  typedef logic [3:0] sqi_data_t;

  typedef enum logic [3:0] {
    StIdle,
    StRestart,
    StCmd0,
    StCmd1,
    StAddr0,
    StAddr1,
    StAddr2,
    StAddr3,
    StDummy0,
    StDummy1,
    StData
  } sqi_state_t;

  localparam logic [7:0]  SQI_CMD_READ     = 8'h03;
  localparam int unsigned SQI_DUMMY_CYCLES = 2;

endpackage

// File: rtl/idli_sqi_m.sv
// SQI SRAM sequential-read controller.
// Streams one nibble per unstalled cycle; SCK is gated off to stall the memory.
module idli_sqi_m
  import idli_pkg::*;
(
  input  logic        i_sqi_gck,
  input  logic        i_sqi_rst,
  input  logic        i_sqi_redirect,
  input  logic [15:0] i_sqi_addr,
  input  logic        i_sqi_stall,
  output sqi_data_t   o_sqi_data,
  output logic        o_sqi_data_vld,
  output logic [15:0] o_sqi_addr,
  output logic        o_sqi_cs_n,
  output logic        o_sqi_sck_en,
  output logic [3:0]  o_sqi_sio,
  output logic        o_sqi_sio_oe,
  input  logic [3:0]  i_sqi_sio
);

  sqi_state_t  r_state;
  sqi_state_t  w_state_d;
  logic [15:0] r_addr;
  logic        r_phase;
  sqi_data_t   r_data;
  logic        r_vld;
  logic        w_adv;

  // A nibble is taken only from an unstalled DATA cycle; redirect wins over it.
  assign w_adv = (r_state == StData) && !i_sqi_stall && !i_sqi_redirect;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:    w_state_d = StIdle;
      StRestart: w_state_d = StCmd0;
      StCmd0:    w_state_d = StCmd1;
      StCmd1:    w_state_d = StAddr0;
      StAddr0:   w_state_d = StAddr1;
      StAddr1:   w_state_d = StAddr2;
      StAddr2:   w_state_d = StAddr3;
      StAddr3:   w_state_d = StDummy0;
      StDummy0:  w_state_d = (SQI_DUMMY_CYCLES > 1) ? StDummy1 : StData;
      StDummy1:  w_state_d = StData;
      StData:    w_state_d = StData;
      default:   w_state_d = StIdle;
    endcase
    if (i_sqi_redirect) begin
      w_state_d = (r_state == StIdle) ? StCmd0 : StRestart;
    end
  end

  always_comb begin
    o_sqi_cs_n   = 1'b1;
    o_sqi_sck_en = 1'b0;
    o_sqi_sio_oe = 1'b0;
    o_sqi_sio    = 4'h0;
    unique case (r_state)
      StIdle, StRestart: begin
      end
      StCmd0, StCmd1, StAddr0, StAddr1, StAddr2, StAddr3: begin
        o_sqi_cs_n   = 1'b0;
        o_sqi_sck_en = 1'b1;
        o_sqi_sio_oe = 1'b1;
        unique case (r_state)
          StCmd0:  o_sqi_sio = SQI_CMD_READ[7:4];
          StCmd1:  o_sqi_sio = SQI_CMD_READ[3:0];
          StAddr0: o_sqi_sio = r_addr[15:12];
          StAddr1: o_sqi_sio = r_addr[11:8];
          StAddr2: o_sqi_sio = r_addr[7:4];
          default: o_sqi_sio = r_addr[3:0];
        endcase
      end
      StDummy0, StDummy1: begin
        o_sqi_cs_n   = 1'b0;
        o_sqi_sck_en = 1'b1;
      end
      StData: begin
        o_sqi_cs_n   = 1'b0;
        o_sqi_sck_en = !i_sqi_stall;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_sqi_gck or posedge i_sqi_rst) begin
    if (i_sqi_rst) begin
      r_state <= StIdle;
      r_addr  <= 16'h0000;
      r_phase <= 1'b0;
      r_data  <= 4'h0;
      r_vld   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_vld   <= w_adv;
      if (i_sqi_redirect) begin
        r_addr  <= i_sqi_addr;
        r_phase <= 1'b0;
      end else if (w_adv) begin
        r_data  <= i_sqi_sio;
        r_phase <= ~r_phase;
        // Low nibble completes the byte; 0xFFFF wraps like the memory does.
        if (r_phase) begin
          r_addr <= r_addr + 16'd1;
        end
      end
    end
  end

  assign o_sqi_data     = r_data;
  assign o_sqi_data_vld = r_vld;
  assign o_sqi_addr     = r_addr;

endmodule

// File: tb/tb_idli_sqi_m.sv
// Directed bench for idli_sqi_m with a behavioural SQI SRAM model.
module tb_idli_sqi_m;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [15:0] addr;
  logic        stall;
  logic [3:0]  data;
  logic        vld;
  logic [15:0] o_addr;
  logic        cs_n;
  logic        sck_en;
  logic [3:0]  sio_o;
  logic        sio_oe;
  logic [3:0]  sio_i;

  int n_tests = 0;
  int n_fail  = 0;

  idli_sqi_m u_dut (
    .i_sqi_gck      (clk),
    .i_sqi_rst      (rst),
    .i_sqi_redirect (redirect),
    .i_sqi_addr     (addr),
    .i_sqi_stall    (stall),
    .o_sqi_data     (data),
    .o_sqi_data_vld (vld),
    .o_sqi_addr     (o_addr),
    .o_sqi_cs_n     (cs_n),
    .o_sqi_sck_en   (sck_en),
    .o_sqi_sio      (sio_o),
    .o_sqi_sio_oe   (sio_oe),
    .i_sqi_sio      (sio_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: two fixed bytes, everything else a simple hash of the address.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    if (a == 16'h1234) return 8'hAB;
    if (a == 16'h1235) return 8'hCD;
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [3:0] mem_nib(input logic [15:0] base, input int k);
    logic [15:0] a;
    logic [7:0]  b;
    a = base + 16'(k >> 1);
    b = mem_byte(a);
    return (k % 2 == 0) ? b[7:4] : b[3:0];
  endfunction

  // SRAM model: counts clocked SCK cycles; cycles 2..5 carry the address.
  int          m_cnt;
  logic [15:0] m_addr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_addr <= 16'h0000;
    end else if (cs_n) begin
      m_cnt <= 0;
    end else if (sck_en) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt >= 2 && m_cnt <= 5) m_addr <= {m_addr[11:0], sio_o};
    end
  end

  assign sio_i = (!cs_n && m_cnt >= 8) ? mem_nib(m_addr, m_cnt - 8) : 4'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called one tick into the CMD0 cycle; ends in the DUMMY1 cycle.
  task automatic hdr(input logic [15:0] a, input string tag);
    logic [3:0] e [6];
    e[0] = 4'h0; e[1] = 4'h3;
    e[2] = a[15:12]; e[3] = a[11:8]; e[4] = a[7:4]; e[5] = a[3:0];
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cyc();
      #1;
      chk($sformatf("%s_cs%0d", tag, i), 32'(cs_n), 32'd0);
      chk($sformatf("%s_sck%0d", tag, i), 32'(sck_en), 32'd1);
      chk($sformatf("%s_oe%0d", tag, i), 32'(sio_oe), 32'(i < 6));
      chk($sformatf("%s_sio%0d", tag, i), 32'(sio_o), 32'((i < 6) ? e[i] : 4'h0));
      chk($sformatf("%s_vld%0d", tag, i), 32'(vld), 32'd0);
    end
  endtask

  task automatic run_1234(input string tag);
    logic [3:0]  ed [4];
    logic [15:0] ea [4];
    ed[0] = 4'hA; ed[1] = 4'hB; ed[2] = 4'hC; ed[3] = 4'hD;
    ea[0] = 16'h1234; ea[1] = 16'h1235; ea[2] = 16'h1235; ea[3] = 16'h1236;
    cyc();
    redirect = 1'b1;
    addr     = 16'h1234;
    #1;
    chk({tag, "_idle_cs"}, 32'(cs_n), 32'd1);
    cyc();
    redirect = 1'b0;
    hdr(16'h1234, tag);
    cyc();
    #1;
    chk({tag, "_data0_vld"}, 32'(vld), 32'd0);
    chk({tag, "_data0_oe"}, 32'(sio_oe), 32'd0);
    for (int j = 0; j < 4; j++) begin
      cyc();
      #1;
      chk($sformatf("%s_vld%0d", tag, j), 32'(vld), 32'd1);
      chk($sformatf("%s_dat%0d", tag, j), 32'(data), 32'(ed[j]));
      chk($sformatf("%s_adr%0d", tag, j), 32'(o_addr), 32'(ea[j]));
    end
  endtask

  initial begin
    logic [3:0]  ed [4];
    logic [15:0] ea [4];
    rst      = 1'b1;
    redirect = 1'b0;
    addr     = 16'h0000;
    stall    = 1'b0;
    #3;
    chk("rst_cs", 32'(cs_n), 32'd1);
    chk("rst_sck", 32'(sck_en), 32'd0);
    chk("rst_oe", 32'(sio_oe), 32'd0);
    chk("rst_sio", 32'(sio_o), 32'd0);
    chk("rst_vld", 32'(vld), 32'd0);
    chk("rst_addr", 32'(o_addr), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    cyc();
    rst = 1'b0;

    run_1234("s1");

    // Stall three cycles: memory holds on nibble 4 (byte 0x1236 = 0x6C).
    stall = 1'b1;
    #1;
    chk("st_sck_first", 32'(sck_en), 32'd0);
    chk("st_vld_first", 32'(vld), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 2) stall = 1'b0;
      #1;
      chk($sformatf("st_gap_vld%0d", i), 32'(vld), 32'd0);
      chk($sformatf("st_gap_sck%0d", i), 32'(sck_en), 32'(i == 2));
      chk($sformatf("st_gap_adr%0d", i), 32'(o_addr), 32'h1236);
    end
    ed[0] = 4'h6; ed[1] = 4'hC; ed[2] = 4'h6; ed[3] = 4'hD;
    ea[0] = 16'h1236; ea[1] = 16'h1237; ea[2] = 16'h1237; ea[3] = 16'h1238;
    for (int j = 0; j < 4; j++) begin
      cyc();
      #1;
      chk($sformatf("st_vld%0d", j), 32'(vld), 32'd1);
      chk($sformatf("st_dat%0d", j), 32'(data), 32'(ed[j]));
      chk($sformatf("st_adr%0d", j), 32'(o_addr), 32'(ea[j]));
    end

    // Redirect from DATA, then again during ADDR1 of the new header.
    redirect = 1'b1;
    addr     = 16'h0500;
    cyc();
    redirect = 1'b0;
    #1;
    chk("rd1_restart_cs", 32'(cs_n), 32'd1);
    chk("rd1_restart_sck", 32'(sck_en), 32'd0);
    chk("rd1_vld", 32'(vld), 32'd0);
    chk("rd1_addr", 32'(o_addr), 32'h0500);
    cyc(); cyc(); cyc(); cyc();
    redirect = 1'b1;
    addr     = 16'h0040;
    #1;
    chk("rd2_addr1_sio", 32'(sio_o), 32'h5);
    cyc();
    redirect = 1'b0;
    #1;
    chk("rd2_restart_cs", 32'(cs_n), 32'd1);
    chk("rd2_restart_sck", 32'(sck_en), 32'd0);
    chk("rd2_restart_oe", 32'(sio_oe), 32'd0);
    chk("rd2_addr", 32'(o_addr), 32'h0040);
    cyc();
    hdr(16'h0040, "rd2");
    cyc();
    #1;
    chk("rd2_lat9_vld", 32'(vld), 32'd0);
    cyc();
    #1;
    chk("rd2_lat10_vld", 32'(vld), 32'd1);
    chk("rd2_dat0", 32'(data), 32'h1);
    cyc();
    #1;
    chk("rd2_dat1", 32'(data), 32'hA);
    chk("rd2_adr1", 32'(o_addr), 32'h0041);

    // Wrap 0xFFFF -> 0x0000: bytes 0xA5 then 0x5A.
    redirect = 1'b1;
    addr     = 16'hFFFF;
    cyc();
    redirect = 1'b0;
    #1;
    chk("wr_restart_cs", 32'(cs_n), 32'd1);
    chk("wr_vld", 32'(vld), 32'd0);
    cyc();
    hdr(16'hFFFF, "wr");
    cyc();
    #1;
    chk("wr_data0_vld", 32'(vld), 32'd0);
    ed[0] = 4'hA; ed[1] = 4'h5; ed[2] = 4'h5; ed[3] = 4'hA;
    ea[0] = 16'hFFFF; ea[1] = 16'h0000; ea[2] = 16'h0000; ea[3] = 16'h0001;
    for (int j = 0; j < 4; j++) begin
      cyc();
      #1;
      chk($sformatf("wr_vld%0d", j), 32'(vld), 32'd1);
      chk($sformatf("wr_dat%0d", j), 32'(data), 32'(ed[j]));
      chk($sformatf("wr_adr%0d", j), 32'(o_addr), 32'(ea[j]));
    end

    // Async reset while stalled in DATA.
    stall = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("ar_cs", 32'(cs_n), 32'd1);
    chk("ar_sck", 32'(sck_en), 32'd0);
    chk("ar_oe", 32'(sio_oe), 32'd0);
    chk("ar_sio", 32'(sio_o), 32'd0);
    chk("ar_vld", 32'(vld), 32'd0);
    chk("ar_addr", 32'(o_addr), 32'd0);
    chk("ar_data", 32'(data), 32'd0);
    cyc();
    rst   = 1'b0;
    stall = 1'b0;
    run_1234("s5");

    // Back-to-back redirects: RESTART stretches, second address wins.
    redirect = 1'b1;
    addr     = 16'h0010;
    cyc();
    addr = 16'h0020;
    #1;
    chk("bb_r1_cs", 32'(cs_n), 32'd1);
    chk("bb_r1_vld", 32'(vld), 32'd0);
    chk("bb_r1_addr", 32'(o_addr), 32'h0010);
    cyc();
    redirect = 1'b0;
    #1;
    chk("bb_r2_cs", 32'(cs_n), 32'd1);
    chk("bb_r2_sck", 32'(sck_en), 32'd0);
    chk("bb_r2_addr", 32'(o_addr), 32'h0020);
    cyc();
    hdr(16'h0020, "bb");
    cyc();
    cyc();
    #1;
    chk("bb_vld", 32'(vld), 32'd1);
    chk("bb_dat", 32'(data), 32'h7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion, expected finish before 100000");
    $fatal(1, "watchdog");
  end

endmodule
